// File: rtl/pipeline_debug_monitor_if.sv
// Debug monitor port bundle: channel handshakes, capture bus, select/read port.
interface pipeline_debug_monitor_if #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 16,
  parameter int CAP_W  = 32
);
  logic                  clear_i;
  logic [NUM_CH-1:0]     vld_i;
  logic [NUM_CH-1:0]     rdy_i;
  logic [ADDR_W-1:0]     trig_addr_i;
  logic [ADDR_W-1:0]     mon_addr_i;
  logic                  mon_en_i;
  logic [CAP_W-1:0]      mon_data_i;
  logic [7:0]            sel_i;
  logic [31:0]           rd_data_o;
  logic [2*NUM_CH-1:0]   sticky_o;

  modport master (
    output clear_i, vld_i, rdy_i, trig_addr_i, mon_addr_i, mon_en_i, mon_data_i, sel_i,
    input  rd_data_o, sticky_o
  );
  modport slave (
    input  clear_i, vld_i, rdy_i, trig_addr_i, mon_addr_i, mon_en_i, mon_data_i, sel_i,
    output rd_data_o, sticky_o
  );
endinterface

// File: rtl/pipeline_debug_monitor.sv
// Pipeline debug monitor: per-channel sticky flags, event/latency counters, address-triggered capture.
// Optional DBG_TIMESTAMP_EN adds a free-running cycle counter latched on first capture.
module pdm_lane #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             vld,
  input  logic             rdy,
  output logic             vld_seen,
  output logic             rdy_seen,
  output logic [CNT_W-1:0] ev_cnt,
  output logic [CNT_W-1:0] lat,
  output logic [1:0]       state
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_seen <= 1'b0;
      rdy_seen <= 1'b0;
      ev_cnt   <= '0;
      lat      <= '0;
      state    <= S_IDLE;
    end else if (clear) begin
      vld_seen <= 1'b0;
      rdy_seen <= 1'b0;
      ev_cnt   <= '0;
      lat      <= '0;
      state    <= S_IDLE;
    end else begin
      if (vld) vld_seen <= 1'b1;
      if (rdy) rdy_seen <= 1'b1;
      if (vld && ev_cnt != CNT_MAX) ev_cnt <= ev_cnt + 1'b1;
      // lat ends up as the cycle distance from first valid to first ready
      case (state)
        S_IDLE: if (vld) begin
          lat   <= '0;
          state <= rdy ? S_DONE : S_RUN;
        end
        S_RUN: begin
          if (lat != CNT_MAX) lat <= lat + 1'b1;
          if (rdy) state <= S_DONE;
        end
        default: ;
      endcase
    end
  end
endmodule

module pipeline_debug_monitor #(
  parameter int          NUM_CH    = 4,
  parameter int          CNT_W     = 32,
  parameter int          ADDR_W    = 16,
  parameter int          CAP_W     = 32,
  parameter logic [31:0] SIGNATURE = 32'd16112003
) (
  input logic                    clk,
  input logic                    rst_n,
  pipeline_debug_monitor_if.slave dbg
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NUM_CH-1:0]            vld_seen, rdy_seen;
  logic [NUM_CH-1:0][CNT_W-1:0] ev_cnt, lat;
  logic [NUM_CH-1:0][1:0]       fsm_state;
  logic                         cap_valid;
  logic [CAP_W-1:0]             cap_data;
  logic [CNT_W-1:0]             hit_cnt;
  logic                         hit;
  logic [31:0]                  rd_nxt, rd_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    pdm_lane #(.CNT_W(CNT_W)) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (dbg.clear_i),
      .vld      (dbg.vld_i[c]),
      .rdy      (dbg.rdy_i[c]),
      .vld_seen (vld_seen[c]),
      .rdy_seen (rdy_seen[c]),
      .ev_cnt   (ev_cnt[c]),
      .lat      (lat[c]),
      .state    (fsm_state[c])
    );
  end

  assign hit = dbg.mon_en_i && (dbg.mon_addr_i == dbg.trig_addr_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_valid <= 1'b0;
      cap_data  <= '0;
      hit_cnt   <= '0;
    end else if (dbg.clear_i) begin
      cap_valid <= 1'b0;
      cap_data  <= '0;
      hit_cnt   <= '0;
    end else if (hit) begin
      if (!cap_valid) begin
        cap_valid <= 1'b1;
        cap_data  <= dbg.mon_data_i;
      end
      if (hit_cnt != CNT_MAX) hit_cnt <= hit_cnt + 1'b1;
    end
  end

`ifdef DBG_TIMESTAMP_EN
  logic [31:0] ts, cap_ts;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts     <= '0;
      cap_ts <= '0;
    end else if (dbg.clear_i) begin
      ts     <= '0;
      cap_ts <= '0;
    end else begin
      ts <= ts + 32'd1;
      if (hit && !cap_valid) cap_ts <= ts;
    end
  end
`endif

  // Readout samples pre-update state, so same-cycle events show the old value
  always_comb begin
    logic [31:0] lat_ext;
    rd_nxt  = '0;
    lat_ext = '0;
    case (dbg.sel_i)
      8'd0: rd_nxt = SIGNATURE;
      8'd1: rd_nxt[2*NUM_CH:0] = {cap_valid, rdy_seen, vld_seen};
      8'd2: rd_nxt = 32'(cap_data);
      8'd3: rd_nxt = 32'(hit_cnt);
      default: ;
    endcase
    for (int c = 0; c < NUM_CH; c++) begin
      if (32'(dbg.sel_i) == 32'(4 + 2*c)) rd_nxt = 32'(ev_cnt[c]);
      if (32'(dbg.sel_i) == 32'(5 + 2*c)) begin
        lat_ext = 32'(lat[c]);
        rd_nxt  = {fsm_state[c], lat_ext[29:0]};
      end
    end
`ifdef DBG_TIMESTAMP_EN
    if (32'(dbg.sel_i) == 32'(4 + 2*NUM_CH)) rd_nxt = cap_ts;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           rd_q <= '0;
    else if (dbg.clear_i) rd_q <= '0;
    else                  rd_q <= rd_nxt;
  end

  assign dbg.rd_data_o = rd_q;
  assign dbg.sticky_o  = {rdy_seen, vld_seen};
endmodule
